// File: rtl/crc16_pkg.sv
// Shared constants and types for the CRC-16/CCITT-FALSE byte engine.
package crc16_pkg;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;

    typedef logic [15:0] crc_t;
    typedef logic [7:0]  byte_t;

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational CRC-16 update for one byte, MSB first, fully unrolled.
module crc16_byte_step
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_CCITT_POLY
) (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    crc_t stage;

    // The loop unrolls into eight shift/XOR stages; bit 15 shifted out is dropped.
    always_comb begin
        stage = crc_in ^ {data_in, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (stage[15]) begin
                stage = {stage[14:0], 1'b0} ^ POLY;
            end else begin
                stage = {stage[14:0], 1'b0};
            end
        end
        crc_out = stage;
    end

endmodule

// File: rtl/crc16_core.sv
// Byte-serial CRC-16 engine: absorbs one byte per clock, framing by reset.
module crc16_core
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_CCITT_POLY,
    parameter logic [15:0] INIT = CRC16_CCITT_INIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data,
    output logic [15:0] crc_code
);

    crc_t crc;
    crc_t crc_next;

    crc16_byte_step #(
        .POLY(POLY)
    ) u_step (
        .crc_in (crc),
        .data_in(data),
        .crc_out(crc_next)
    );

    // No enable: every edge out of reset consumes the byte on data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= INIT;
        end else begin
            crc <= crc_next;
        end
    end

    assign crc_code = crc;

endmodule

// File: tb/tb_crc16_core.sv
// Self-checking bench for crc16_core: directed vectors, check string and bitwise model.
module tb_crc16_core;
    import crc16_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data;
    logic [15:0] crc_code;
    logic [7:0]  zero_data;
    logic [15:0] zero_crc;

    int checks;
    int failures;

    typedef struct {
        logic [7:0]  din;
        logic [15:0] expected;
    } vec_t;

    vec_t vectors[4];
    logic [7:0] check_str[9];

    crc16_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .crc_code(crc_code)
    );

    crc16_core #(
        .POLY(16'h1021),
        .INIT(16'h0000)
    ) dut_zero (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (zero_data),
        .crc_code(zero_crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-at-a-time reference: feedback is crc MSB XOR the incoming message bit.
    function automatic logic [15:0] modelStep(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            fb = r[15] ^ d[b];
            r = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset asserted away from any clock edge, held across an edge, then released.
    task automatic pulseReset(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        data  = 8'hA5;
        #1;
        checkOutput({name, "_async"}, crc_code, 16'hFFFF);
        @(posedge clk);
        #1;
        checkOutput({name, "_held"}, crc_code, 16'hFFFF);
        releaseReset();
    endtask

    initial begin
        logic [15:0] model;
        logic [7:0]  rnd;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        data      = 8'h00;
        zero_data = 8'h00;

        vectors[0] = '{din: 8'h41, expected: 16'hB915};
        vectors[1] = '{din: 8'h00, expected: 16'hE1F0};
        vectors[2] = '{din: 8'hFF, expected: 16'hFF00};
        vectors[3] = '{din: 8'h31, expected: 16'hC782};
        for (int i = 0; i < 9; i++) check_str[i] = 8'h31 + 8'(i);

        pulseReset("reset");

        // Single-byte vectors, each from a fresh reset.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i].din);
            checkOutput($sformatf("byte_%h", vectors[i].din), crc_code, vectors[i].expected);
            pulseReset($sformatf("reset_after_%0d", i));
        end

        // Check string.
        for (int i = 0; i < 9; i++) applyStimulus(check_str[i]);
        checkOutput("check_string", crc_code, 16'h29B1);
        checkOutput("zero_absorb", zero_crc, 16'h0000);

        // Partial message, then reset mid-stream and restart.
        pulseReset("pre_midstream");
        for (int i = 0; i < 4; i++) applyStimulus(check_str[i]);
        pulseReset("midstream");
        for (int i = 0; i < 9; i++) applyStimulus(check_str[i]);
        checkOutput("check_string_after_reset", crc_code, 16'h29B1);

        // Random bytes against the bitwise model, every cycle.
        pulseReset("pre_random");
        model = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            rnd = 8'($urandom_range(0, 255));
            model = modelStep(model, rnd);
            applyStimulus(rnd);
            checkOutput($sformatf("random_%0d", i), crc_code, model);
        end
        checkOutput("zero_absorb_end", zero_crc, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
